// File: rtl/irq_pkg.sv
// Shared constants and helpers for the multi-source interrupt controller.
// Cause encoding follows the RISC-V mcause layout (interrupt bit in MSB).
package irq_pkg;

  localparam int          IRQ_CAUSE_BIT       = 31;
  localparam logic [31:0] ILLEGAL_INSTR_CAUSE = 32'h2;
  localparam int          DEF_CAUSE_BASE      = 16;
  localparam int          MAX_IRQ             = 32;

  function automatic logic [31:0] irq_cause(
    input int unsigned idx,
    input int unsigned base
  );
    logic [31:0] c;
    c = 32'(idx + base);
    c[IRQ_CAUSE_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of elig wins.
// Purely combinational.
module irq_prio_enc #(
  parameter  int N  = 16,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  output logic [SW-1:0] sel,
  output logic          any
);

  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) sel = SW'(i);
    end
    any = |elig;
  end

endmodule

// File: rtl/irq_controller_multi.sv
// N-source interrupt controller with fixed priority, per-source edge/level
// mode, exception/interrupt handling flags and one-hot return acknowledge.
module irq_controller_multi
  import irq_pkg::*;
#(
  parameter int               N_IRQ      = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  parameter int               CAUSE_BASE = DEF_CAUSE_BASE,
  localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exception_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic [N_IRQ-1:0] pending_o
);

  logic [N_IRQ-1:0] r_req_q;
  logic [N_IRQ-1:0] r_pend;
  logic             r_exc_h;
  logic             r_irq_h;
  logic [SEL_W-1:0] r_svc_idx;

  logic [N_IRQ-1:0] w_elig;
  logic [SEL_W-1:0] w_sel;
  logic             w_any;
  logic             w_take;
  logic             w_ret;
  logic [N_IRQ-1:0] w_acc;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_pend_nxt;

  assign w_elig = r_pend & mie_i;

  irq_prio_enc #(
    .N(N_IRQ)
  ) u_prio (
    .elig(w_elig),
    .sel (w_sel),
    .any (w_any)
  );

  assign w_take = w_any & ~r_exc_h & ~r_irq_h & ~exception_i;
  assign w_ret  = mret_i & ~exception_i & ~r_exc_h & r_irq_h;
  assign w_acc  = w_take ? (N_IRQ'(1) << w_sel) : '0;
  assign w_rise = irq_req_i & ~r_req_q;

  // Edge sources: a new edge beats acceptance; level sources track the line.
  assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_acc) | w_rise))
                    | (~EDGE_MASK & irq_req_i);

  assign irq_o       = w_take;
  assign irq_cause_o = w_take ? irq_cause(32'(w_sel), CAUSE_BASE) : '0;
  assign irq_ret_o   = w_ret ? (N_IRQ'(1) << r_svc_idx) : '0;
  assign pending_o   = r_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_q <= '0;
      r_pend  <= '0;
    end else begin
      r_req_q <= irq_req_i;
      r_pend  <= w_pend_nxt;
    end
  end

  // The exception handler always returns before the interrupt handler.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exc_h <= 1'b0;
    end else if (exception_i) begin
      r_exc_h <= 1'b1;
    end else if (mret_i && r_exc_h) begin
      r_exc_h <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_h   <= 1'b0;
      r_svc_idx <= '0;
    end else if (w_take) begin
      r_irq_h   <= 1'b1;
      r_svc_idx <= w_sel;
    end else if (w_ret) begin
      r_irq_h   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Directed bench for irq_controller_multi with a cycle-level reference
// model compared on every falling edge outside reset.
module tb_irq_controller_multi;

  localparam int          N    = 16;
  localparam logic [15:0] EDGE = 16'h00FE;
  localparam int          BASE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc;
  logic        mret;
  logic [15:0] req;
  logic [15:0] mie;
  logic        irq;
  logic [31:0] cause;
  logic [15:0] ret;
  logic [15:0] pend;

  int errors = 0;
  int checks = 0;

  irq_controller_multi #(
    .N_IRQ     (N),
    .EDGE_MASK (EDGE),
    .CAUSE_BASE(BASE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .exception_i(exc),
    .irq_req_i  (req),
    .mie_i      (mie),
    .mret_i     (mret),
    .irq_o      (irq),
    .irq_cause_o(cause),
    .irq_ret_o  (ret),
    .pending_o  (pend)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_pend[N];
  bit m_reqq[N];
  bit m_exc;
  bit m_irqh;
  int m_svc;

  function automatic int exp_sel();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && mie[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit exp_irq();
    return (exp_sel() >= 0) && !m_exc && !m_irqh && !exc;
  endfunction

  function automatic logic [31:0] exp_cause();
    if (!exp_irq()) return 32'h0;
    return 32'h8000_0000 + 32'(BASE) + 32'(exp_sel());
  endfunction

  function automatic bit exp_ret_ok();
    return mret && !exc && !m_exc && m_irqh;
  endfunction

  function automatic logic [15:0] exp_ret();
    logic [15:0] v;
    v = 16'h0;
    if (exp_ret_ok()) v[m_svc] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] exp_pend();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 1'b0;
        m_reqq[i] <= 1'b0;
      end
      m_exc  <= 1'b0;
      m_irqh <= 1'b0;
      m_svc  <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (EDGE[i]) begin
          if (req[i] && !m_reqq[i]) m_pend[i] <= 1'b1;
          else if (exp_irq() && exp_sel() == i) m_pend[i] <= 1'b0;
        end else begin
          m_pend[i] <= req[i];
        end
        m_reqq[i] <= req[i];
      end
      if (exc) m_exc <= 1'b1;
      else if (mret && m_exc) m_exc <= 1'b0;
      if (exp_irq()) begin
        m_irqh <= 1'b1;
        m_svc  <= exp_sel();
      end else if (exp_ret_ok()) begin
        m_irqh <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model irq_o", 32'(irq), 32'(exp_irq()));
      chk("model cause", cause, exp_cause());
      chk("model ret", 32'(ret), 32'(exp_ret()));
      chk("model pending", 32'(pend), 32'(exp_pend()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; exc = 1'b0; mret = 1'b0; req = '0; mie = '0;
    #2;
    chk("reset irq_o", 32'(irq), 32'h0);
    chk("reset cause", cause, 32'h0);
    chk("reset ret", 32'(ret), 32'h0);
    chk("reset pending", 32'(pend), 32'h0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Single edge pulse on source 3
    step();
    mie = 16'h0008; req = 16'h0008;
    step(); req = '0;
    #1 chk("s1 irq", 32'(irq), 32'h1);
    chk("s1 cause", cause, 32'h8000_0013);
    step();
    #1 chk("s1 irq low", 32'(irq), 32'h0);
    chk("s1 pend clr", 32'(pend), 32'h0);
    mret = 1'b1;
    #1 chk("s1 ret", 32'(ret), 32'h0008);
    step(); mret = 1'b0;

    // Sources 2 and 5 together
    mie = 16'h0024; req = 16'h0024;
    step(); req = '0;
    #1 chk("s2 cause2", cause, 32'h8000_0012);
    step(); mret = 1'b1;
    #1 chk("s2 ret2", 32'(ret), 32'h0004);
    chk("s2 no irq", 32'(irq), 32'h0);
    step(); mret = 1'b0;
    #1 chk("s2 irq5", 32'(irq), 32'h1);
    chk("s2 cause5", cause, 32'h8000_0015);
    step(); mret = 1'b1;
    #1 chk("s2 ret5", 32'(ret), 32'h0020);
    step(); mret = 1'b0;

    // Masked edge on source 7 is held until enabled
    mie = '0; req = 16'h0080;
    step(); req = '0;
    repeat (10) step();
    #1 chk("s3 held", 32'(pend), 32'h0080);
    chk("s3 masked", 32'(irq), 32'h0);
    mie = 16'h0080;
    #1 chk("s3 irq", 32'(irq), 32'h1);
    chk("s3 cause", cause, 32'h8000_0017);
    step(); mret = 1'b1;
    #1 chk("s3 ret", 32'(ret), 32'h0080);
    step(); mret = 1'b0;

    // Exception inside an interrupt handler
    mie = 16'h0008; req = 16'h0008;
    step(); req = '0;
    #1 chk("s4 irq", 32'(irq), 32'h1);
    step(); exc = 1'b1;
    #1 chk("s4 exc irq", 32'(irq), 32'h0);
    step(); exc = 1'b0; mret = 1'b1;
    #1 chk("s4 ret exc", 32'(ret), 32'h0);
    step();
    #1 chk("s4 ret irq", 32'(ret), 32'h0008);
    step(); mret = 1'b0;

    // Exception blocks a level request, which returns after mret
    mie = 16'h0001; req = 16'h0001;
    step(); exc = 1'b1;
    #1 chk("s5 exc blk", 32'(irq), 32'h0);
    step(); exc = 1'b0;
    #1 chk("s5 exc_h blk", 32'(irq), 32'h0);
    mret = 1'b1;
    #1 chk("s5 ret0", 32'(ret), 32'h0);
    step(); mret = 1'b0;
    #1 chk("s5 irq", 32'(irq), 32'h1);
    chk("s5 cause", cause, 32'h8000_0010);
    step(); mret = 1'b1;
    #1 chk("s5 ret", 32'(ret), 32'h0001);
    req = '0;
    step(); mret = 1'b0;
    #1 chk("s5 idle", 32'(irq), 32'h0);

    // Asynchronous reset mid-handler
    mie = 16'h0008; req = 16'h0028;
    step(); req = '0;
    step(); mret = 1'b1;
    #1 chk("s6 ret pre", 32'(ret), 32'h0008);
    chk("s6 pend pre", 32'(pend), 32'h0020);
    rst = 1'b1;
    #1 chk("s6 rst irq", 32'(irq), 32'h0);
    chk("s6 rst cause", cause, 32'h0);
    chk("s6 rst ret", 32'(ret), 32'h0);
    chk("s6 rst pend", 32'(pend), 32'h0);
    mret = 1'b0;
    step();
    step(); rst = 1'b0;
    step(); mret = 1'b1;
    #1 chk("s6 ret post", 32'(ret), 32'h0);
    chk("s6 irq post", 32'(irq), 32'h0);
    step(); mret = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller_multi.md
# irq_controller_multi

Parametrised successor to the core's single-line interrupt controller. It accepts `N_IRQ` interrupt sources, each configurable as level- or edge-triggered. It latches pending requests, picks the lowest-index enabled pending source by fixed priority, and signals a trap to the core with a RISC-V mcause value. It tracks exception and interrupt handling state and returns a one-hot `irq_ret_o` to the serviced source on `mret`. It sits between the peripheral interrupt lines and `processor_core`, in place of the single-channel controller.

## Interface
Parameters:
- `N_IRQ`, 16 — number of interrupt sources; legal range 1..32.
- `EDGE_MASK`, `'0` — `N_IRQ` bits; bit i = 1 makes source i edge-triggered, 0 makes it level-triggered.
- `CAUSE_BASE`, 16 — mcause code of source 0; source i reports code `CAUSE_BASE + i`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named `clk_i` and `rst_i`.
- `clk_i`  in  1  — core clock.
- `rst_i`  in  1  — asynchronous active-high reset.
- `exception_i`  in  1  — synchronous exception (illegal instruction) in the current cycle.
- `irq_req_i`  in  N_IRQ  — interrupt request lines from peripherals.
- `mie_i`  in  N_IRQ  — per-source enable, driven from CSR `mie[CAUSE_BASE +: N_IRQ]`.
- `mret_i`  in  1  — current instruction is `mret`.
- `irq_o`  out  1  — take an interrupt trap this cycle.
- `irq_cause_o`  out  32  — mcause value; valid when `irq_o` = 1, otherwise 0.
- `irq_ret_o`  out  N_IRQ  — one-hot return acknowledge to the serviced source.
- `pending_o`  out  N_IRQ  — registered pending vector, for the mip view.

## Operation
- **Edge source i:**
  - `req_q[i]` is a registered copy of `irq_req_i[i]`.
  - A rising edge (`irq_req_i[i] & ~req_q[i]`) sets `pend[i]`.
  - `pend[i]` clears at the clock edge on which source i is accepted.
  - If a new edge and acceptance occur in the same cycle, set wins.
- **Level source i:** `pend[i] <= irq_req_i[i]` every cycle. The peripheral must hold the request until it sees `irq_ret_o[i]`.
- **Eligibility:**
  - `elig = pend & mie_i`.
  - `sel` = lowest set index of `elig`; `any` = OR of `elig`.
  - Masked pending edge sources stay pending and are not lost.
- **Trap and cause:**
  - `irq_o = any & ~exc_h & ~irq_h & ~exception_i`.
  - `irq_cause_o = {1'b1, 31'(CAUSE_BASE + sel)}` when `irq_o` = 1, else 0.
- **State flags:** `exc_h` and `irq_h`, plus the `svc_idx` register.
  - On `exception_i` = 1: `exc_h <= 1`. Exception has priority over interrupts; `irq_o` = 0 that cycle. A nested exception leaves `exc_h` at 1.
  - On `irq_o` = 1: `irq_h <= 1`, `svc_idx <= sel`.
  - On `mret_i` = 1 with `exception_i` = 0:
    - If `exc_h` = 1: clear `exc_h` only. The exception handler returns first.
    - Else if `irq_h` = 1: clear `irq_h` and assert `irq_ret_o` = onehot(`svc_idx`) in the same cycle (combinational).
    - Else: no effect, and `irq_ret_o` = 0.
  - If `exception_i` and `mret_i` are both 1, `exception_i` wins and `mret_i` is ignored.
- **Nesting:** no interrupt nesting. A new interrupt is accepted only once both `exc_h` and `irq_h` are 0.

## Timing
- Reset values: `pend`, `req_q`, `exc_h`, `irq_h` and `svc_idx` are all 0. Consequently `irq_o`, `irq_cause_o`, `irq_ret_o` and `pending_o` are all 0.
- Latency:
  - Edge or level request at input → `irq_o` high in the next cycle (1 register stage), when the source is enabled and the controller is idle.
  - `irq_o` and `irq_ret_o` are combinational from registered state plus `exception_i`/`mret_i`, and are valid in the same cycle.
- `irq_o` stays high only for the cycle of acceptance; the next cycle `irq_h` = 1 forces it to 0.
- A level source still asserted after `irq_ret_o` is re-accepted 1 cycle after `irq_h` clears.
- An asynchronous reset mid-handler clears all state immediately. Outputs go to 0 with no clock edge required.

## Structure
- Package `irq_pkg`:
  - `IRQ_CAUSE_BIT` = 31.
  - `ILLEGAL_INSTR_CAUSE` = 32'h2.
  - Default `CAUSE_BASE` = 16.
  - `MAX_IRQ` = 32.
  - Function `irq_cause(idx, base)`.
- Sub-module `irq_prio_enc` (parameter `N`): input `elig`; outputs `sel[$clog2(N)-1:0]` and `any`. Purely combinational; lowest index wins.

## Test plan
- Reset, then pulse `irq_req_i[3]` for 1 cycle (edge source, `mie_i` = 16'h0008) → `irq_o` = 1 one cycle later, `irq_cause_o` = 32'h8000_0013, `pend[3]` cleared after acceptance.
- `irq_req_i[5]` and `irq_req_i[2]` rise together, both enabled → source 2 is served first (cause 32'h8000_0012). `mret_i` → `irq_ret_o` = 16'h0004. Source 5 is accepted 1 cycle later if it is an edge source.
- Edge source 7 pulses while `mie_i[7]` = 0; set `mie_i[7]` 10 cycles later → `irq_o` = 1 with cause 32'h8000_0017.
- During `irq_h`, assert `exception_i` → `exc_h` = 1. First `mret_i` → `irq_ret_o` = 0, `exc_h` cleared. Second `mret_i` → `irq_ret_o` = onehot(`svc_idx`).
- `exception_i` and `irq_req_i[0]` (level, enabled) together → `irq_o` = 0 in that cycle. `mret_i` → level source 0 re-accepted.
- Assert `rst_i` asynchronously mid-handler → all outputs 0 before the next clock edge; `mret_i` after release → `irq_ret_o` = 0.
